// File: rtl/y86_hazard_ctrl_v2.sv
// y86_hazard_ctrl_v2: Y86 five-stage hazard detection, stall/bubble control, halt FSM and perf counters
module y86_hazard_ctrl_v2 #(
  parameter int ICODE_W = 4,
  parameter int REG_W = 4,
  parameter int STAT_W = 3,
  parameter int CNT_W = 16,
  parameter logic [ICODE_W-1:0] I_MRMOV = ICODE_W'(5),
  parameter logic [ICODE_W-1:0] I_POP = ICODE_W'(11),
  parameter logic [ICODE_W-1:0] I_JXX = ICODE_W'(7),
  parameter logic [ICODE_W-1:0] I_RET = ICODE_W'(9),
  parameter logic [REG_W-1:0] RNONE = REG_W'(15),
  parameter logic [STAT_W-1:0] S_AOK = STAT_W'(1),
  parameter logic [STAT_W-1:0] S_HLT = STAT_W'(2),
  parameter logic [STAT_W-1:0] S_ADR = STAT_W'(3),
  parameter logic [STAT_W-1:0] S_INS = STAT_W'(4)
) (
  input  logic clk,
  input  logic rst,
  input  logic [ICODE_W-1:0] D_icode,
  input  logic [ICODE_W-1:0] E_icode,
  input  logic [ICODE_W-1:0] M_icode,
  input  logic [REG_W-1:0] d_srcA,
  input  logic [REG_W-1:0] d_srcB,
  input  logic [REG_W-1:0] E_dstM,
  input  logic e_cnd,
  input  logic [STAT_W-1:0] m_stat,
  input  logic [STAT_W-1:0] W_stat,
  input  logic dmem_busy,
  output logic F_stall,
  output logic D_stall,
  output logic D_bubble,
  output logic E_stall,
  output logic E_bubble,
  output logic M_stall,
  output logic M_bubble,
  output logic W_stall,
  output logic W_bubble,
  output logic halted,
  output logic [STAT_W-1:0] halt_stat,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_cycles
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t r_state;
  logic w_ret, w_lu, w_mis, w_mexc, w_wexc, w_exc, w_hlt, w_run, w_busy, w_norm;
  assign w_ret = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign w_lu = ((E_icode == I_MRMOV) || (E_icode == I_POP)) && (E_dstM != RNONE) &&
                ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign w_mis = (E_icode == I_JXX) && !e_cnd;
  assign w_mexc = (m_stat == S_HLT) || (m_stat == S_ADR) || (m_stat == S_INS);
  assign w_wexc = (W_stat == S_HLT) || (W_stat == S_ADR) || (W_stat == S_INS);
  assign w_exc = w_mexc || w_wexc;
  assign w_hlt = r_state == HALTED;
  assign w_run = !rst && !w_hlt;
  // a W-stage exception outranks a memory wait, so busy only freezes when W is clean
  assign w_busy = w_run && !w_wexc && dmem_busy;
  assign w_norm = w_run && !w_busy;
  assign halted = w_hlt;
  always_comb begin
    F_stall = !rst && (w_hlt || w_busy || (w_norm && (w_ret || w_lu)));
    D_stall = !rst && (w_hlt || w_busy || (w_norm && w_lu));
    D_bubble = w_norm && (w_mis || w_ret) && !(w_lu && w_ret);
    E_stall = !rst && (w_hlt || w_busy);
    E_bubble = w_norm && (w_lu || w_mis);
    M_stall = !rst && (w_hlt || w_busy);
    M_bubble = w_norm && w_exc;
    W_stall = !rst && (w_hlt || w_wexc);
    W_bubble = w_busy;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      halt_stat <= S_AOK;
      stall_cycles <= '0;
      bubble_cycles <= '0;
    end else begin
      if (!w_hlt && w_wexc) begin
        r_state <= HALTED;
        halt_stat <= W_stat;
      end else if (r_state == RUN && w_exc) r_state <= DRAIN;
      else if (r_state == DRAIN && !w_exc) r_state <= RUN;
      if (F_stall && !w_hlt && stall_cycles != {CNT_W{1'b1}}) stall_cycles <= stall_cycles + 1'b1;
      if ((E_bubble || W_bubble) && bubble_cycles != {CNT_W{1'b1}}) bubble_cycles <= bubble_cycles + 1'b1;
    end
  end
endmodule

// File: tb/tb_y86_hazard_ctrl_v2.sv
// tb_y86_hazard_ctrl_v2: directed scoreboard bench for the hazard controller (16-bit and 4-bit counter builds)
module tb_y86_hazard_ctrl_v2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, e_cnd, dmem_busy;
  logic [3:0] D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM;
  logic [2:0] m_stat, W_stat;
  logic F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble, W_stall, W_bubble, halted;
  logic [2:0] halt_stat;
  logic [15:0] stall_cycles, bubble_cycles;
  logic f4, d4, db4, e4, eb4, m4, mb4, w4, wb4, h4;
  logic [2:0] hs4;
  logic [3:0] sc4, bc4;
  logic [8:0] ctrl, ctrl4;
  assign ctrl = {F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble, W_stall, W_bubble};
  assign ctrl4 = {f4, d4, db4, e4, eb4, m4, mb4, w4, wb4};
  y86_hazard_ctrl_v2 dut (
    .clk(clk), .rst(rst), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_cnd(e_cnd), .m_stat(m_stat),
    .W_stat(W_stat), .dmem_busy(dmem_busy), .F_stall(F_stall), .D_stall(D_stall),
    .D_bubble(D_bubble), .E_stall(E_stall), .E_bubble(E_bubble), .M_stall(M_stall),
    .M_bubble(M_bubble), .W_stall(W_stall), .W_bubble(W_bubble), .halted(halted),
    .halt_stat(halt_stat), .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
  );
  y86_hazard_ctrl_v2 #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_cnd(e_cnd), .m_stat(m_stat),
    .W_stat(W_stat), .dmem_busy(dmem_busy), .F_stall(f4), .D_stall(d4),
    .D_bubble(db4), .E_stall(e4), .E_bubble(eb4), .M_stall(m4),
    .M_bubble(mb4), .W_stall(w4), .W_bubble(wb4), .halted(h4),
    .halt_stat(hs4), .stall_cycles(sc4), .bubble_cycles(bc4)
  );
  typedef struct packed {logic [8:0] c; logic h; logic [2:0] hs;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [15:0] m_sc = '0, m_bc = '0;
  logic [3:0] m_sc4 = '0, m_bc4 = '0;
  logic m_h = 1'b0;
  localparam logic [8:0] C_LU = 9'b110010000, C_MIS = 9'b001010000, C_BUSY = 9'b110101001;
  localparam logic [8:0] C_HALT = 9'b110101010, C_RET = 9'b101000000;
  task automatic idle();
    rst = 1'b0; D_icode = 4'd1; E_icode = 4'd1; M_icode = 4'd1;
    d_srcA = 4'd0; d_srcB = 4'd0; E_dstM = 4'd15; e_cnd = 1'b1;
    dmem_busy = 1'b0; m_stat = 3'd1; W_stat = 3'd1;
  endtask
  task automatic step(input logic [8:0] c, input logic h, input logic [2:0] hs);
    exp_t e;
    q.push_back(exp_t'({c, h, hs}));
    #1;
    e = q.pop_front();
    checks++;
    assert (ctrl === e.c) else begin errors++; $error("FAIL ctrl obs=%b exp=%b", ctrl, e.c); end
    checks++;
    assert (ctrl4 === e.c) else begin errors++; $error("FAIL ctrl4 obs=%b exp=%b", ctrl4, e.c); end
    if (rst) begin
      m_sc = '0; m_bc = '0; m_sc4 = '0; m_bc4 = '0; m_h = 1'b0;
    end else begin
      if (e.c[8] && !m_h) begin
        if (m_sc != 16'hFFFF) m_sc++;
        if (m_sc4 != 4'hF) m_sc4++;
      end
      if (e.c[4] || e.c[0]) begin
        if (m_bc != 16'hFFFF) m_bc++;
        if (m_bc4 != 4'hF) m_bc4++;
      end
      m_h = e.h;
    end
    @(posedge clk);
    #1;
    checks++;
    assert (halted === e.h) else begin errors++; $error("FAIL halted obs=%b exp=%b", halted, e.h); end
    checks++;
    assert (halt_stat === e.hs) else begin errors++; $error("FAIL halt_stat obs=%0d exp=%0d", halt_stat, e.hs); end
    checks++;
    assert (stall_cycles === m_sc) else begin errors++; $error("FAIL stall_cycles obs=%0d exp=%0d", stall_cycles, m_sc); end
    checks++;
    assert (bubble_cycles === m_bc) else begin errors++; $error("FAIL bubble_cycles obs=%0d exp=%0d", bubble_cycles, m_bc); end
    checks++;
    assert (sc4 === m_sc4) else begin errors++; $error("FAIL stall_cycles4 obs=%0d exp=%0d", sc4, m_sc4); end
    checks++;
    assert (bc4 === m_bc4) else begin errors++; $error("FAIL bubble_cycles4 obs=%0d exp=%0d", bc4, m_bc4); end
    @(negedge clk);
  endtask
  initial begin
    idle(); rst = 1'b1;
    step(9'd0, 1'b0, 3'd1);
    step(9'd0, 1'b0, 3'd1);
    rst = 1'b0;
    step(9'd0, 1'b0, 3'd1);
    E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3;
    step(C_LU, 1'b0, 3'd1);
    E_dstM = 4'd15; d_srcA = 4'd0; d_srcB = 4'd15;
    step(9'd0, 1'b0, 3'd1);
    idle(); E_icode = 4'd7; e_cnd = 1'b0;
    step(C_MIS, 1'b0, 3'd1);
    e_cnd = 1'b1;
    step(9'd0, 1'b0, 3'd1);
    idle(); E_icode = 4'd11; E_dstM = 4'd4; d_srcB = 4'd4; D_icode = 4'd9;
    step(C_LU, 1'b0, 3'd1);
    idle(); E_icode = 4'd7; e_cnd = 1'b0; dmem_busy = 1'b1;
    repeat (3) step(C_BUSY, 1'b0, 3'd1);
    dmem_busy = 1'b0;
    step(C_MIS, 1'b0, 3'd1);
    idle(); m_stat = 3'd3;
    step(9'b000000100, 1'b0, 3'd1);
    m_stat = 3'd1; W_stat = 3'd3;
    step(9'b000000110, 1'b1, 3'd3);
    W_stat = 3'd1; D_icode = 4'd9;
    step(C_HALT, 1'b1, 3'd3);
    idle(); dmem_busy = 1'b1;
    step(C_HALT, 1'b1, 3'd3);
    W_stat = 3'd4;
    step(C_HALT, 1'b1, 3'd3);
    rst = 1'b1;
    step(9'd0, 1'b0, 3'd1);
    idle(); m_stat = 3'd4;
    step(9'b000000100, 1'b0, 3'd1);
    m_stat = 3'd1;
    step(9'd0, 1'b0, 3'd1);
    D_icode = 4'd9;
    repeat (20) step(C_RET, 1'b0, 3'd1);
    checks++;
    assert (sc4 === 4'd15) else begin errors++; $error("FAIL sat4 obs=%0d exp=15", sc4); end
    dmem_busy = 1'b1; rst = 1'b1;
    step(9'd0, 1'b0, 3'd1);
    idle(); dmem_busy = 1'b1;
    step(C_BUSY, 1'b0, 3'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/y86_hazard_ctrl_v2.md
# y86_hazard_ctrl_v2

Parametrised second-generation hazard and pipeline-control unit for the five-stage Y86 pipeline (F, D, E, M, W). It detects load/use, ret, mispredicted-branch, exception and multi-cycle data-memory hazards. For each pipeline register it drives per-stage stall and bubble controls. It also holds a sticky halt state machine and saturating performance counters. It sits beside the pipeline registers, fed by decoded stage fields; its outputs gate the register enables and the bubble inserts.

## Interface
- ICODE_W, 4, instruction-code width
- REG_W, 4, register-ID width
- STAT_W, 3, status-code width
- CNT_W, 16, performance-counter width
- I_MRMOV, 5 / I_POP, 11 / I_JXX, 7 / I_RET, 9, icode encodings
- RNONE, 15, "no register" ID (never matches for hazard purposes)
- S_AOK, 1 / S_HLT, 2 / S_ADR, 3 / S_INS, 4, status encodings

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- D_icode, E_icode, M_icode  in  ICODE_W  stage instruction codes
- d_srcA, d_srcB  in  REG_W  decode-stage source registers
- E_dstM  in  REG_W  execute-stage memory destination register
- e_cnd  in  1  branch condition computed in E
- m_stat, W_stat  in  STAT_W  memory-stage (post-access) and write-back status
- dmem_busy  in  1  data memory has not completed the M-stage access this cycle
- F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble, W_stall, W_bubble  out  1 each  pipeline-register controls
- halted  out  1  state is HALTED
- halt_stat  out  STAT_W  first non-AOK status that reached W
- stall_cycles, bubble_cycles  out  CNT_W  saturating counters

## Operation
Hazard terms (combinational):
- ret = I_RET present in D, E or M.
- lu = E_icode is I_MRMOV or I_POP, E_dstM != RNONE, and E_dstM equals d_srcA or d_srcB.
- mis = (E_icode == I_JXX) && !e_cnd.
- exc = m_stat or W_stat is in {S_HLT, S_ADR, S_INS}.
- wexc = W_stat is in {S_HLT, S_ADR, S_INS}.

State machine, 2-bit register, states RUN, DRAIN, HALTED:
- RUN -> DRAIN when exc && !wexc.
- RUN or DRAIN -> HALTED when wexc.
- DRAIN -> RUN when !exc (the faulting instruction was squashed upstream).
- HALTED is sticky until rst.
- On entry to HALTED, halt_stat latches W_stat; halt_stat holds thereafter.

Output priority, first match wins:
1. rst=1: all nine controls 0.
2. HALTED: F_stall=D_stall=E_stall=M_stall=W_stall=1; all bubbles 0.
3. wexc (any state): W_stall=1, M_bubble=1; F, D and E follow rules 5–6.
4. dmem_busy (RUN/DRAIN): F_stall=D_stall=E_stall=M_stall=1, W_bubble=1; D_bubble=E_bubble=0 even if lu/mis/ret.
5. Normal:
   - F_stall = ret || lu
   - D_stall = lu
   - D_bubble = (mis || ret) && !(lu && ret)
   - E_bubble = lu || mis
6. M_bubble = exc in rules 3 and 5.
   - E_stall=M_stall=W_bubble=0 except as above.
   - W_stall = wexc.

Invariant: no stage ever has stall and bubble both 1.

Counters:
- stall_cycles increments on cycles where F_stall=1 and state != HALTED.
- bubble_cycles increments on cycles where E_bubble=1 or W_bubble=1.
- Both saturate at 2^CNT_W−1 (no wrap) and clear to 0 on rst.

## Timing
- Controls are combinational from current inputs plus the state register, with zero-cycle latency into the same edge's register enables.
- State, halt_stat and counters update on the rising edge of clk; halted is a registered output.
- Reset values: state RUN, halted=0, halt_stat=S_AOK, counters 0, all controls 0.
- rst asserted mid-stall or in HALTED returns to RUN on the next edge; it takes priority over every transition and counter increment that cycle.
- dmem_busy held for N cycles gives N cycles of full freeze with W_bubble each cycle. The cycle after it deasserts evaluates normal hazards on unchanged D/E contents.
- Simultaneous lu and ret: D stalls and is not bubbled. Simultaneous mis and lu: E bubbles, D stalls.

## Test plan
- mrmov to r3 in E, d_srcA=3 → F_stall=D_stall=E_bubble=1, D_bubble=0. Repeat with E_dstM=RNONE=15 and d_srcB=15 → all controls 0.
- E_icode=7, e_cnd=0 → D_bubble=E_bubble=1, F_stall=0, bubble_cycles +1.
- E_icode=11 with lu true and D_icode=9 → F_stall=D_stall=E_bubble=1, D_bubble=0.
- dmem_busy=1 for 3 cycles with mis also true → F/D/E/M_stall=1, W_bubble=1, D_bubble=E_bubble=0 each cycle; stall_cycles +3, bubble_cycles +3.
- m_stat=3 for one cycle, then W_stat=3 → DRAIN with M_bubble=1, then HALTED, halt_stat=3, all stalls 1. Assert rst → halted=0 and counters 0 after one edge.
- CNT_W=4, hold ret for 20 cycles → stall_cycles saturates at 15.
